// File: rtl/mlp_load_sequencer.sv
// mlp_load_sequencer: feeds one MLP layer into MLP_acc_top.
// It reads the input matrix and weight SRAMs and replays 256 row-interleaved
// load beats onto the accelerator load interface. It then counts the returned
// result beats and pulses done_o when the expected number has arrived.
// Optional feature: define MLP_SEQ_PERF_CNT_EN to enable the busy-cycle
// counter on perf_cycles_o. When it is undefined, that output is tied to 0.
module mlp_load_sequencer #(
    parameter int DATA_W       = 16,
    parameter int RESULT_BEATS = 128,
    parameter int PERF_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [2:0]          layer_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                in_rd_en_o,
    output logic [6:0]          in_rd_addr_o,
    input  logic [2*DATA_W-1:0] in_rd_data_i,
    output logic                w_rd_en_o,
    output logic [9:0]          w_rd_addr_o,
    input  logic [2*DATA_W-1:0] w_rd_data_i,
    output logic                load_en_o,
    output logic [2*DATA_W-1:0] load_payload_o,
    output logic                load_type_o,
    output logic [3:0]          input_load_number_o,
    output logic [2:0]          layer_number_o,
    output logic [2:0]          weight_number_o,
    input  logic                result_valid_i,
    output logic [PERF_W-1:0]   perf_cycles_o
);

    localparam int RW = $clog2(RESULT_BEATS + 1);
    localparam logic [RW-1:0] RES_MAX = RW'(RESULT_BEATS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_RES} state_t;

    state_t        state;
    logic [7:0]    bc;
    logic          drain_cnt;
    logic [RW-1:0] res_cnt;

    // stage 0 tags sit beside the registered SRAM address
    logic       v0, t0;
    logic [3:0] r0;
    logic [2:0] i0;
    // stage 1 tags line up with the SRAM read data
    logic       v1, t1;
    logic [3:0] r1;
    logic [2:0] i1;

    // Control FSM: issues one SRAM read per ISSUE cycle and tracks the results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            bc             <= '0;
            drain_cnt      <= 1'b0;
            res_cnt        <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            in_rd_en_o     <= 1'b0;
            in_rd_addr_o   <= '0;
            w_rd_en_o      <= 1'b0;
            w_rd_addr_o    <= '0;
            layer_number_o <= '0;
            v0             <= 1'b0;
            t0             <= 1'b0;
            r0             <= '0;
            i0             <= '0;
        end else begin
            done_o     <= 1'b0;
            in_rd_en_o <= 1'b0;
            w_rd_en_o  <= 1'b0;
            v0         <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state          <= ISSUE;
                        busy_o         <= 1'b1;
                        layer_number_o <= layer_i;
                        bc             <= '0;
                        res_cnt        <= '0;
                    end
                end
                ISSUE: begin
                    v0 <= 1'b1;
                    t0 <= ~bc[3];
                    r0 <= bc[7:4];
                    i0 <= bc[2:0];
                    if (!bc[3]) begin
                        in_rd_en_o   <= 1'b1;
                        in_rd_addr_o <= {bc[7:4], bc[2:0]};
                    end else begin
                        w_rd_en_o   <= 1'b1;
                        w_rd_addr_o <= {layer_number_o, bc[7:4], bc[2:0]};
                    end
                    bc <= bc + 8'd1;
                    if (bc == 8'hFF) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) state <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (res_cnt == RES_MAX) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (state != IDLE && result_valid_i && res_cnt != RES_MAX)
                res_cnt <= res_cnt + 1'b1;
        end
    end

    // Beat pipeline: carries the tags past the SRAM latency and registers the payload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1                  <= 1'b0;
            t1                  <= 1'b0;
            r1                  <= '0;
            i1                  <= '0;
            load_en_o           <= 1'b0;
            load_payload_o      <= '0;
            load_type_o         <= 1'b0;
            input_load_number_o <= '0;
            weight_number_o     <= '0;
        end else begin
            v1        <= v0;
            t1        <= t0;
            r1        <= r0;
            i1        <= i0;
            load_en_o <= v1;
            if (v1) begin
                load_payload_o      <= t1 ? in_rd_data_i : w_rd_data_i;
                load_type_o         <= t1;
                input_load_number_o <= r1;
                if (!t1) weight_number_o <= i1;
            end else begin
                load_payload_o <= '0;
                load_type_o    <= 1'b0;
            end
        end
    end

`ifdef MLP_SEQ_PERF_CNT_EN
    // Busy-cycle counter: cleared on start and frozen once the job returns to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_cycles_o <= '0;
        else if (state == IDLE && start_i)
            perf_cycles_o <= '0;
        else if (state != IDLE)
            perf_cycles_o <= perf_cycles_o + PERF_W'(1);
    end
`else
    assign perf_cycles_o = '0;
`endif

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Directed bench for mlp_load_sequencer: beat order, load timing, result
// counting, start-while-busy, reset mid-job and the perf counter.
module tb_mlp_load_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  layer_i;
    logic        busy_o, done_o;
    logic        in_rd_en_o;
    logic [6:0]  in_rd_addr_o;
    logic [31:0] in_rd_data_i;
    logic        w_rd_en_o;
    logic [9:0]  w_rd_addr_o;
    logic [31:0] w_rd_data_i;
    logic        load_en_o;
    logic [31:0] load_payload_o;
    logic        load_type_o;
    logic [3:0]  input_load_number_o;
    logic [2:0]  layer_number_o;
    logic [2:0]  weight_number_o;
    logic        result_valid_i;
    logic [31:0] perf_cycles_o;

    int n_cmp;
    int n_bad;

    mlp_load_sequencer #(.DATA_W(16), .RESULT_BEATS(128), .PERF_W(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start_i             (start_i),
        .layer_i             (layer_i),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .in_rd_en_o          (in_rd_en_o),
        .in_rd_addr_o        (in_rd_addr_o),
        .in_rd_data_i        (in_rd_data_i),
        .w_rd_en_o           (w_rd_en_o),
        .w_rd_addr_o         (w_rd_addr_o),
        .w_rd_data_i         (w_rd_data_i),
        .load_en_o           (load_en_o),
        .load_payload_o      (load_payload_o),
        .load_type_o         (load_type_o),
        .input_load_number_o (input_load_number_o),
        .layer_number_o      (layer_number_o),
        .weight_number_o     (weight_number_o),
        .result_valid_i      (result_valid_i),
        .perf_cycles_o       (perf_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // X[r][c] = r + c, so word(r, p) = {r+2p+1, r+2p}
    function automatic logic [31:0] x_word(input int r, input int p);
        return {16'(r + 2 * p + 1), 16'(r + 2 * p)};
    endfunction

    // expected payload of beat b (all weights are 1)
    function automatic logic [31:0] exp_word(input int b);
        logic [7:0] bb;
        bb = 8'(b);
        if (!bb[3]) return x_word(int'(bb[7:4]), int'(bb[2:0]));
        return 32'h0001_0001;
    endfunction

    // SRAM models with 1-cycle synchronous read
    always @(posedge clk) begin
        if (in_rd_en_o) in_rd_data_i <= x_word(int'(in_rd_addr_o[6:3]), int'(in_rd_addr_o[2:0]));
        if (w_rd_en_o)  w_rd_data_i  <= 32'h0001_0001;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bd[256];
    logic        bt[256];
    logic [3:0]  br[256];
    logic [2:0]  bw[256];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, first_k, last_k, done_cnt, done_k, flag_layer, flag_waddr, bad_beats;
        logic [7:0] bb;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start_i = 1'b0;
        layer_i = 3'd0;
        result_valid_i = 1'b0;
        in_rd_data_i = '0;
        w_rd_data_i = '0;
        repeat (3) tick();
        check_eq("reset_outputs", {31'b0, |{busy_o, done_o, in_rd_en_o, in_rd_addr_o, w_rd_en_o,
                 w_rd_addr_o, load_en_o, load_payload_o, load_type_o, input_load_number_o,
                 layer_number_o, weight_number_o, perf_cycles_o}}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- job A: layer 0, beat order, timing, 127 + 1 results, start while busy
        nb = 0; first_k = -1; last_k = -1; done_cnt = 0; done_k = -1;
        flag_layer = 0; flag_waddr = 0;
        start_i = 1'b1;
        layer_i = 3'd0;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= 410; k++) begin
            start_i = (k == 50);
            layer_i = (k == 50) ? 3'd5 : 3'd0;
            result_valid_i = (k >= 259 && k <= 385) || k == 401 || (k >= 403 && k <= 405);
            tick();
            if (k == 1) check_eq("busy_after_start", {31'b0, busy_o}, 32'd1);
            if (k == 2) check_eq("idle_payload_pre", {load_payload_o[30:0], load_type_o}, 32'd0);
            if (k == 259) check_eq("idle_payload_post", {load_payload_o[30:0], load_type_o}, 32'd0);
            if (k == 259) check_eq("hold_row_wn", {25'b0, input_load_number_o, weight_number_o}, {25'b0, 4'd15, 3'd7});
            if (k == 400) check_eq("busy_after_127", {31'b0, busy_o}, 32'd1);
            if (k == 403) check_eq("busy_after_done", {31'b0, busy_o}, 32'd0);
            if (load_en_o) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                if (nb < 256) begin
                    bd[nb] = load_payload_o;
                    bt[nb] = load_type_o;
                    br[nb] = input_load_number_o;
                    bw[nb] = weight_number_o;
                end
                nb++;
            end
            if (layer_number_o != 3'd0) flag_layer++;
            if (w_rd_addr_o[9:7] != 3'd0) flag_waddr++;
            if (done_o) begin
                done_cnt++;
                done_k = k;
            end
        end
        result_valid_i = 1'b0;
        check_eq("load_first_cycle", first_k, 32'd3);
        check_eq("load_beat_count", nb, 32'd256);
        check_eq("load_last_cycle", last_k, 32'd258);
        check_eq("done_count", done_cnt, 32'd1);
        check_eq("done_cycle", done_k, 32'd402);
        check_eq("layer_ignored", flag_layer, 32'd0);
        check_eq("waddr_layer0", flag_waddr, 32'd0);
        check_eq("beat0_data", bd[0], 32'h0001_0000);
        check_eq("beat0_tags", {27'b0, bt[0], br[0]}, {27'b0, 1'b1, 4'd0});
        check_eq("beat7_data", bd[7], 32'h000F_000E);
        check_eq("beat8_data", bd[8], 32'h0001_0001);
        check_eq("beat8_tags", {25'b0, bt[8], bw[8]}, {25'b0, 1'b0, 3'd0});
        check_eq("beat255_tags", {24'b0, bt[255], br[255], bw[255]}, {24'b0, 1'b0, 4'd15, 3'd7});
        bad_beats = 0;
        for (int b = 0; b < 256; b++) begin
            bb = 8'(b);
            if (bd[b] !== exp_word(b) || bt[b] !== ~bb[3] || br[b] !== bb[7:4] ||
                (!bb[3] ? 1'b0 : (bw[b] !== bb[2:0])))
                bad_beats++;
        end
        check_eq("beat_order_all", bad_beats, 32'd0);

        // ---- job B: reset at beat 100
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= 103; k++) tick();
        check_eq("beat100_data", load_payload_o, exp_word(100));
        rst_n = 1'b0;
        tick();
        check_eq("midjob_reset_outputs", {31'b0, |{busy_o, done_o, in_rd_en_o, in_rd_addr_o, w_rd_en_o,
                 w_rd_addr_o, load_en_o, load_payload_o, load_type_o, input_load_number_o,
                 layer_number_o, weight_number_o, perf_cycles_o}}, 32'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done_o || busy_o || load_en_o) done_cnt++;
        end
        check_eq("quiet_after_reset", done_cnt, 32'd0);

        // ---- job C: layer 3, replay from beat 0, back-to-back results, perf
        done_cnt = 0; done_k = -1; flag_waddr = 0;
        start_i = 1'b1;
        layer_i = 3'd3;
        tick();
        start_i = 1'b0;
        layer_i = 3'd0;
        for (int k = 1; k <= 395; k++) begin
            result_valid_i = (k >= 259 && k <= 386);
            tick();
            if (k == 3) begin
                check_eq("replay_beat0_data", load_payload_o, 32'h0001_0000);
                check_eq("replay_beat0_type", {31'b0, load_type_o}, 32'd1);
            end
            if (k == 11) check_eq("l3_beat8", load_payload_o, 32'h0001_0001);
            if (w_rd_en_o && w_rd_addr_o[9:7] != 3'd3) flag_waddr++;
            if (done_o) begin
                done_cnt++;
                done_k = k;
            end
        end
        result_valid_i = 1'b0;
        check_eq("l3_layer_number", {29'b0, layer_number_o}, 32'd3);
        check_eq("l3_waddr_layer", flag_waddr, 32'd0);
        check_eq("l3_done_cycle", done_k, 32'd387);
        check_eq("l3_done_count", done_cnt, 32'd1);
`ifdef MLP_SEQ_PERF_CNT_EN
        check_eq("perf_cycles", perf_cycles_o, 32'd387);
`else
        check_eq("perf_cycles", perf_cycles_o, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
